// File: rtl/whack_scorer.sv
`timescale 1ns/1ps
// whack_scorer
// Scores one round of whack-a-mole. Each raw button is synchronized,
// debounced and falling-edge detected. Every press is then judged against
// the lit moles while a round is running. The score saturates at 0..99 and
// is kept as BCD digits.
//
// Ports:
//   clk         system clock; every flop is clocked on its rising edge
//   reset       synchronous, active-high; returns the block to IDLE
//   start       level from a slide switch; a rising edge starts a round
//   key_n       raw active-low buttons, asynchronous to clk
//   mole_on     currently lit moles; sampled directly
//   score_bin   binary score 0..99 (10*tens + ones)
//   score_ones  BCD ones digit
//   score_tens  BCD tens digit
//   hit_pulse   one-cycle pulse per scored hit
//   miss_pulse  one-cycle pulse per penalized miss
//   playing     high while a round is running
//   game_over   high after the round timer has expired
module whack_scorer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ROUND_CYCLES    = 1500000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_KEYS-1:0] mole_on,
    output logic [7:0]        score_bin,
    output logic [3:0]        score_ones,
    output logic [3:0]        score_tens,
    output logic              hit_pulse,
    output logic              miss_pulse,
    output logic              playing,
    output logic              game_over
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(ROUND_CYCLES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    // ---------------- key conditioning ----------------
    logic [N_KEYS-1:0] sync1, sync2, stable, press;
    logic [DW-1:0]     db_cnt [N_KEYS];

    // NOTE: sequential state is always assigned with <= so that every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            press  <= '0;
            // NOTE: the debounce counters are individual flops rather than a
            // RAM, so clearing them all on reset is legal and intended.
            for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                    // Counter has seen DEBOUNCE_CYCLES differing cycles: accept.
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= ~sync2[i];   // only the 1->0 transition is a press
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // ---------------- round FSM and score ----------------
    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [3:0]    ones, tens, ones_next, tens_next;
    logic          start_q, start_rise;
    logic          hit, miss, clear;

    assign start_rise = start & ~start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            ones       <= '0;
            tens       <= '0;
            start_q    <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            ones       <= ones_next;
            tens       <= tens_next;
            start_q    <= start;
            hit_pulse  <= hit;
            miss_pulse <= miss;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        timer_next = timer;
        clear      = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        ones_next  = ones;
        tens_next  = tens;

        unique case (state)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_next = PLAY;
                    timer_next = TW'(ROUND_CYCLES - 1);
                    clear      = 1'b1;
                end
            end
            PLAY: begin
                // The press in the last PLAY cycle is still judged below.
                if (timer == '0) state_next = OVER;
                else             timer_next = timer - TW'(1);
                hit  = |(press & mole_on);
                miss = |(press & ~mole_on) & ~hit;
            end
            default: state_next = IDLE;
        endcase

        if (clear) begin
            ones_next = '0;
            tens_next = '0;
        end else if (hit) begin
            if (!(tens == 4'd9 && ones == 4'd9)) begin
                if (ones == 4'd9) begin
                    ones_next = '0;
                    tens_next = tens + 4'd1;
                end else begin
                    ones_next = ones + 4'd1;
                end
            end
        end else if (miss) begin
            if (!(tens == 4'd0 && ones == 4'd0)) begin
                if (ones == 4'd0) begin
                    ones_next = 4'd9;
                    tens_next = tens - 4'd1;
                end else begin
                    ones_next = ones - 4'd1;
                end
            end
        end
    end

    // 10*tens = 8*tens + 2*tens
    assign score_bin  = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, ones};
    assign score_ones = ones;
    assign score_tens = tens;
    assign playing    = (state == PLAY);
    assign game_over  = (state == OVER);

endmodule

// File: tb/tb_whack_scorer.sv
`timescale 1ns/1ps
// Testbench for whack_scorer. Two instances share all inputs: one with the
// 64-cycle round for round timing, one with a long round so that long press
// sequences fit inside a single round. A scoreboard queue holds the expected
// pulse kind and score; a monitor pops it whenever the long-round instance
// pulses hit_pulse or miss_pulse.
module tb_whack_scorer;

    localparam int N_KEYS     = 4;
    localparam int DEB        = 4;
    localparam int ROUND      = 64;
    localparam int LONG_ROUND = 4000;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [N_KEYS-1:0] key_n, mole_on;

    logic [7:0] s_bin, l_bin;
    logic [3:0] s_ones, s_tens, l_ones, l_tens;
    logic       s_hit, s_miss, s_play, s_over;
    logic       l_hit, l_miss, l_play, l_over;

    whack_scorer #(.N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DEB), .ROUND_CYCLES(ROUND)) dut (
        .clk(clk), .reset(reset), .start(start), .key_n(key_n), .mole_on(mole_on),
        .score_bin(s_bin), .score_ones(s_ones), .score_tens(s_tens),
        .hit_pulse(s_hit), .miss_pulse(s_miss), .playing(s_play), .game_over(s_over)
    );

    whack_scorer #(.N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DEB), .ROUND_CYCLES(LONG_ROUND)) dut_long (
        .clk(clk), .reset(reset), .start(start), .key_n(key_n), .mole_on(mole_on),
        .score_bin(l_bin), .score_ones(l_ones), .score_tens(l_tens),
        .hit_pulse(l_hit), .miss_pulse(l_miss), .playing(l_play), .game_over(l_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_hit;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   model_score = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (l_hit || l_miss) begin
                check("pulse_exclusive", longint'(l_hit & l_miss), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_queue_size", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_is_hit", longint'(l_hit), longint'(e.is_hit));
                    check("sb_score_bin", longint'(l_bin), e.score);
                    check("sb_score_tens", longint'(l_tens), e.score / 10);
                    check("sb_score_ones", longint'(l_ones), e.score % 10);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (l_hit || l_miss) c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        key_n   = '1;
        reset   = 1'b1;
        cycles(2);
        reset   = 1'b0;
        cycles(1);
        model_score = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    // Press the keys in mask with the given moles lit; push the expected outcome.
    task automatic press(input logic [N_KEYS-1:0] mask, input logic [N_KEYS-1:0] mole);
        exp_t e;
        bit   h, m;
        h = |(mask & mole);
        m = !h && |(mask & ~mole);
        if (h) model_score = (model_score < 99) ? model_score + 1 : 99;
        else if (m) model_score = (model_score > 0) ? model_score - 1 : 0;
        e.is_hit = h;
        e.score  = model_score;
        if (h || m) exp_q.push_back(e);
        mole_on = mole;
        key_n   = ~mask;
        cycles(10);
        key_n   = '1;
        cycles(10);
    endtask

    initial begin
        int first, cnt, c1, c2;
        reset   = 1'b1;
        start   = 1'b0;
        key_n   = '1;
        mole_on = '0;
        cycles(1);
        do_reset();

        // Reset state
        check("rst_score_bin", s_bin, 0);
        check("rst_score_ones", s_ones, 0);
        check("rst_score_tens", s_tens, 0);
        check("rst_hit_pulse", s_hit, 0);
        check("rst_miss_pulse", s_miss, 0);
        check("rst_playing", s_play, 0);
        check("rst_game_over", s_over, 0);
        check("rst_long_score_bin", l_bin, 0);

        // Start: playing one cycle later, score 0; round lasts exactly 64 cycles
        do_start();
        check("start_playing", s_play, 1);
        check("start_score", s_bin, 0);
        check("start_long_playing", l_play, 1);
        cnt = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (s_play) cnt++;
            else break;
        end
        check("round_play_cycles", cnt, ROUND);
        check("round_game_over", s_over, 1);
        check("round_playing_low", s_play, 0);
        @(posedge clk);
        #1;

        // Single hit: latency from first low sample to hit_pulse
        model_score = 1;
        exp_q.push_back('{is_hit: 1'b1, score: 1});
        mole_on = 4'b0001;
        key_n   = 4'b1110;
        first   = 0;
        cnt     = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            #1;
            if (j == 10) key_n = '1;
            @(negedge clk);
            if (l_hit) begin
                cnt++;
                if (first == 0) first = j;
            end
        end
        @(posedge clk);
        #1;
        check("hit_latency_edges", first, 7 + 1);
        check("hit_pulse_count", cnt, 1);
        check("hit1_ones", l_ones, 1);
        check("hit1_tens", l_tens, 0);
        check("hit1_bin", l_bin, 1);

        // Up to 12, then a miss
        repeat (11) press(4'b0001, 4'b0001);
        check("hit12_bin", l_bin, 12);
        check("hit12_tens", l_tens, 1);
        check("hit12_ones", l_ones, 2);
        press(4'b0100, 4'b0001);
        check("miss11_bin", l_bin, 11);

        // Simultaneous lit + dark key counts as one hit
        press(4'b0011, 4'b0001);
        check("simul_bin", l_bin, 12);

        // 3-cycle glitch: no press
        mole_on = 4'b0001;
        key_n   = 4'b1110;
        cycles(3);
        key_n   = '1;
        count_pulses(15, c1);
        check("glitch_pulses", c1, 0);
        check("glitch_bin", l_bin, 12);

        // Miss at score 0
        do_reset();
        do_start();
        press(4'b0100, 4'b0001);
        check("miss_at0_bin", l_bin, 0);

        // Saturation at 99
        do_reset();
        do_start();
        repeat (101) press(4'b0001, 4'b0001);
        check("sat_bin", l_bin, 99);
        check("sat_tens", l_tens, 9);
        check("sat_ones", l_ones, 9);
        check("sat_still_playing", l_play, 1);

        // Mid-round reset at 37
        do_reset();
        do_start();
        repeat (37) press(4'b0001, 4'b0001);
        check("pre_reset_bin", l_bin, 37);
        check("pre_reset_tens", l_tens, 3);
        check("pre_reset_ones", l_ones, 7);
        reset = 1'b1;
        cycles(1);
        check("midrst_bin", l_bin, 0);
        check("midrst_playing", l_play, 0);
        check("midrst_game_over", l_over, 0);
        reset = 1'b0;
        mole_on = 4'b0001;
        key_n   = 4'b1110;
        count_pulses(10, c1);
        key_n   = '1;
        count_pulses(10, c2);
        check("idle_press_pulses", c1 + c2, 0);
        check("idle_bin", l_bin, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
